// File: rtl/parallel_serial_packer.sv
// Serial frame capture and packer: NCH lines are cut into FRAME_WIDTH-bit frames and
// emitted MSB-first as tagged 36-bit words through an internal standard FIFO.
package parallel_serial_packer_pkg;
  typedef struct packed {
    logic        sof;
    logic [2:0]  chan;
    logic [31:0] data;
  } pack_word_t;
endpackage

module parallel_serial_packer
  import parallel_serial_packer_pkg::*;
#(
  parameter int unsigned NCH         = 8,
  parameter int unsigned FRAME_WIDTH = 48,
  parameter int unsigned NDATA       = 1,
  parameter int unsigned FIFO_AW     = 9
) (
  input  logic           clk_in,
  input  logic           rst,
  input  logic           start,
  input  logic           stop,
  input  logic           mode,
  input  logic [NCH-1:0] fd,
  input  logic           fifo_rd_en,
  output logic [35:0]    fifo_q,
  output logic           fifo_empty,
  output logic           fifo_full,
  output logic           busy,
  output logic           done,
  output logic [15:0]    drop_cnt
);

  localparam int unsigned WPF   = (FRAME_WIDTH + 31) / 32;
  localparam int unsigned PW    = WPF * 32;
  localparam int unsigned PADW  = PW - FRAME_WIDTH;
  localparam int unsigned BCW   = $clog2(FRAME_WIDTH);
  localparam int unsigned WDW   = (WPF > 1) ? $clog2(WPF) : 1;
  localparam int unsigned FCW   = NDATA + 1;
  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  // Packing a frame must finish before the next snapshot lands.
  if (NCH < 1 || NCH > 8 || FRAME_WIDTH < 2 || NCH * WPF > FRAME_WIDTH) begin : g_cfg_check
    $error("parallel_serial_packer: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t                 state;
  logic [BCW-1:0]         bit_cnt;
  logic [FCW-1:0]         frame_cnt;
  logic                   mode_q;
  logic                   stop_seen;
  logic                   pack_active;
  logic [2:0]             pack_ch;
  logic [WDW-1:0]         pack_wd;
  logic [FRAME_WIDTH-2:0] shreg [NCH];
  logic [FRAME_WIDTH-1:0] snap  [NCH];

  logic                   frame_end_c;
  logic                   last_frame_c;
  logic [FRAME_WIDTH-1:0] sel_frame_c;
  logic [PW-1:0]          padded_c;
  int unsigned            word_sh_c;
  pack_word_t             pack_word_c;

  logic [35:0]            mem [DEPTH];
  logic [FIFO_AW-1:0]     wr_ptr;
  logic [FIFO_AW-1:0]     rd_ptr;
  logic [CW-1:0]          count;
  logic                   wr_try_c;
  logic                   wr_ok_c;
  logic                   rd_ok_c;
  logic [CW-1:0]          next_count_c;

  // Frame boundary and end-of-run decision.
  always_comb begin
    frame_end_c  = 1'b0;
    last_frame_c = 1'b0;
    frame_end_c  = (state == CAPTURE) && (bit_cnt == BCW'(FRAME_WIDTH - 1));
    last_frame_c = stop || stop_seen || (!mode_q && (frame_cnt == FCW'(2 ** NDATA - 1)));
  end

  // Current output word: selected channel snapshot, left-aligned, sliced 32 bits at a time.
  always_comb begin
    sel_frame_c = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      if (pack_ch == 3'(c)) sel_frame_c = snap[c];
    end
    padded_c         = PW'(sel_frame_c) << PADW;
    word_sh_c        = 32 * (WPF - 1 - 32'(pack_wd));
    pack_word_c.sof  = (pack_wd == '0);
    pack_word_c.chan = pack_ch;
    pack_word_c.data = 32'(padded_c >> word_sh_c);
  end

  // Run control and packer sequencing; start overrides everything else.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      frame_cnt   <= '0;
      mode_q      <= 1'b0;
      stop_seen   <= 1'b0;
      pack_active <= 1'b0;
      pack_ch     <= '0;
      pack_wd     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state       <= CAPTURE;
        bit_cnt     <= '0;
        frame_cnt   <= '0;
        mode_q      <= mode;
        stop_seen   <= 1'b0;
        pack_active <= 1'b0;
        pack_ch     <= '0;
        pack_wd     <= '0;
        busy        <= 1'b1;
      end else begin
        if (pack_active) begin
          if (pack_wd == WDW'(WPF - 1)) begin
            pack_wd <= '0;
            if (pack_ch == 3'(NCH - 1)) begin
              pack_ch     <= '0;
              pack_active <= 1'b0;
            end else begin
              pack_ch <= pack_ch + 3'd1;
            end
          end else begin
            pack_wd <= pack_wd + WDW'(1);
          end
        end
        case (state)
          CAPTURE: begin
            if (stop) stop_seen <= 1'b1;
            if (frame_end_c) begin
              bit_cnt     <= '0;
              frame_cnt   <= frame_cnt + FCW'(1);
              pack_active <= 1'b1;
              pack_ch     <= '0;
              pack_wd     <= '0;
              if (last_frame_c) state <= DRAIN;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
          DRAIN: begin
            if (!pack_active) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Per-line shift registers; the completing bit goes straight into the snapshot.
  always_ff @(posedge clk_in) begin
    if (state == CAPTURE && !start) begin
      for (int c = 0; c < int'(NCH); c++) begin
        shreg[c] <= (FRAME_WIDTH - 1)'({shreg[c], fd[c]});
        if (frame_end_c) snap[c] <= {shreg[c], fd[c]};
      end
    end
  end

  always_comb begin
    wr_try_c     = 1'b0;
    wr_ok_c      = 1'b0;
    rd_ok_c      = 1'b0;
    next_count_c = '0;
    wr_try_c     = pack_active && !start;
    wr_ok_c      = wr_try_c && !fifo_full;
    rd_ok_c      = fifo_rd_en && !fifo_empty && !start;
    next_count_c = count + CW'(wr_ok_c) - CW'(rd_ok_c);
  end

  always_ff @(posedge clk_in) begin
    if (wr_ok_c) mem[wr_ptr] <= pack_word_c;
  end

  // FIFO pointers, registered flags and drop accounting; start flushes.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      fifo_q     <= '0;
      drop_cnt   <= '0;
    end else if (start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (wr_ok_c) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (rd_ok_c) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
        fifo_q <= mem[rd_ptr];
      end
      if (wr_try_c && fifo_full && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      count      <= next_count_c;
      fifo_empty <= (next_count_c == '0);
      fifo_full  <= (next_count_c == CW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_parallel_serial_packer.sv
// Bench for parallel_serial_packer: table of runs against a frame-level word model,
// plus hand sequences for overflow, restart, async reset and FIFO edge cases.
module tb_parallel_serial_packer;

  localparam int NCH  = 8;
  localparam int FW   = 48;
  localparam int WPF  = 2;
  localparam int WPFR = NCH * WPF;

  logic           clk_in = 1'b0;
  logic           rst;
  logic           start;
  logic           stop;
  logic           mode;
  logic [NCH-1:0] fd;
  logic           fifo_rd_en;
  logic [35:0]    fifo_q;
  logic           fifo_empty;
  logic           fifo_full;
  logic           busy;
  logic           done;
  logic [15:0]    drop_cnt;

  always #5 clk_in = ~clk_in;

  parallel_serial_packer #(
    .NCH(NCH), .FRAME_WIDTH(FW), .NDATA(1), .FIFO_AW(4)
  ) dut (
    .clk_in(clk_in), .rst(rst), .start(start), .stop(stop), .mode(mode), .fd(fd),
    .fifo_rd_en(fifo_rd_en), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .busy(busy), .done(done), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic m;
    int   stop_edge;
    int   pat;
    int   nfr;
    int   done_at;
  } vec_t;

  vec_t        tbl [6];
  logic [FW-1:0] fr [8][NCH];
  logic [35:0] got [$];
  logic [35:0] exp_q [$];
  int          gen_n, done_cnt, done_at;
  int          checks, errors;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Bit j of word k counts from the frame MSB; positions past bit 0 are zero padding.
  function automatic logic [35:0] model_word(input logic [FW-1:0] fv, input int c, input int k);
    logic [31:0] d;
    d = '0;
    for (int j = 0; j < 32; j++) begin
      int b;
      b = FW - 1 - 32 * k - j;
      if (b >= 0) d[31-j] = fv[b];
    end
    return {(k == 0), 3'(c), d};
  endfunction

  function automatic void build_exp(input int nfr);
    exp_q.delete();
    for (int f = 0; f < nfr; f++)
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < WPF; k++)
          exp_q.push_back(model_word(fr[f][c], c, k));
  endfunction

  function automatic void fill_pat(input int pat);
    for (int f = 0; f < 8; f++)
      for (int c = 0; c < NCH; c++)
        fr[f][c] = (pat == 0) ? (48'hA000_0000_0000 | 48'(c)) : {16'($urandom), 32'($urandom)};
  endfunction

  // After edge n of a run, line c presents bit n of its frame stream (MSB first).
  function automatic void drive_fd();
    int f, b;
    f = (gen_n / FW) % 8;
    b = FW - 1 - (gen_n % FW);
    for (int c = 0; c < NCH; c++) fd[c] = fr[f][c][b];
  endfunction

  task automatic cycle();
    logic pre_rd, pre_empty, pre_start;
    pre_rd    = fifo_rd_en;
    pre_empty = fifo_empty;
    pre_start = start;
    @(posedge clk_in);
    #1;
    if (pre_start) begin
      gen_n    = 0;
      got.delete();
      done_cnt = 0;
      done_at  = -1;
    end else begin
      gen_n++;
      if (pre_rd && !pre_empty) got.push_back(fifo_q);
    end
    if (done) begin
      done_cnt++;
      if (done_at < 0) done_at = gen_n;
    end
    drive_fd();
  endtask

  task automatic pulse_start(input logic m);
    mode  = m;
    stop  = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic run_to(input int g);
    for (int n = 0; n < 4000 && gen_n < g; n++) cycle();
  endtask

  task automatic wait_done(input string nm, input int stop_edge);
    for (int n = 0; n < 2000 && done_cnt == 0; n++) begin
      stop = (gen_n + 1 == stop_edge);
      cycle();
    end
    stop = 1'b0;
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 2000 cycles", nm);
    end
  endtask

  task automatic cmp_all(input string nm);
    chk({nm, "_nwords"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_word%0d", nm, i), 64'(got[i]), 64'(exp_q[i]));
  endtask

  initial begin
    // Mode, stop sample edge (0 = none), pattern, frames expected, done edge after start.
    tbl[0] = '{1'b0, 0,            0, 2, 2 * FW + WPFR + 1};
    tbl[1] = '{1'b1, 5 * FW + 20,  1, 6, 6 * FW + WPFR + 1};
    tbl[2] = '{1'b0, 20,           1, 1, 1 * FW + WPFR + 1};
    tbl[3] = '{1'b1, FW,           1, 1, 1 * FW + WPFR + 1};
    tbl[4] = '{1'b1, FW + 1,       1, 2, 2 * FW + WPFR + 1};
    tbl[5] = '{1'b0, 100,          1, 2, 2 * FW + WPFR + 1};

    checks = 0; errors = 0;
    gen_n = 0; done_cnt = 0; done_at = -1;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; fd = '0; fifo_rd_en = 1'b0;
    fill_pat(1);
    #12;
    chk("rst_fifo_q", 64'(fifo_q), 64'(0));
    chk("rst_empty", 64'(fifo_empty), 64'(1));
    chk("rst_full", 64'(fifo_full), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));
    rst = 1'b0;
    fifo_rd_en = 1'b1;
    repeat (3) cycle();
    chk("idle_rd_empty_q", 64'(fifo_q), 64'(0));
    chk("idle_rd_empty_cnt", 64'(got.size()), 64'(0));

    // Table runs with a continuous reader.
    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("tbl%0d", i);
      fill_pat(tbl[i].pat);
      build_exp(tbl[i].nfr);
      fifo_rd_en = 1'b1;
      pulse_start(tbl[i].m);
      chk({nm, "_busy_run"}, 64'(busy), 64'(1));
      wait_done(nm, tbl[i].stop_edge);
      chk({nm, "_done_at"}, 64'(done_at), 64'(tbl[i].done_at));
      chk({nm, "_busy_end"}, 64'(busy), 64'(0));
      repeat (4) cycle();
      chk({nm, "_done_pulses"}, 64'(done_cnt), 64'(1));
      chk({nm, "_drop"}, 64'(drop_cnt), 64'(0));
      cmp_all(nm);
      if (tbl[i].pat == 0 && got.size() >= WPFR) begin
        for (int c = 0; c < NCH; c++) begin
          logic [31:0] w1;
          w1 = 32'(c) << 16;
          chk($sformatf("t1_w0_ch%0d", c), 64'(got[2*c]), 64'({1'b1, 3'(c), 32'hA000_0000}));
          chk($sformatf("t1_w1_ch%0d", c), 64'(got[2*c+1]), 64'({1'b0, 3'(c), w1}));
        end
      end
    end

    // Overflow with no reads: first 16 words kept, 16 dropped.
    fill_pat(1);
    build_exp(2);
    fifo_rd_en = 1'b0;
    pulse_start(1'b0);
    wait_done("ovf", 0);
    chk("ovf_done_at", 64'(done_at), 64'(2 * FW + WPFR + 1));
    chk("ovf_full", 64'(fifo_full), 64'(1));
    chk("ovf_empty", 64'(fifo_empty), 64'(0));
    chk("ovf_drop", 64'(drop_cnt), 64'(16));
    fifo_rd_en = 1'b1;
    repeat (17) cycle();
    fifo_rd_en = 1'b0;
    chk("ovf_nwords", 64'(got.size()), 64'(16));
    for (int i = 0; i < got.size() && i < 16; i++)
      chk($sformatf("ovf_word%0d", i), 64'(got[i]), 64'(exp_q[i]));
    chk("ovf_empty_after", 64'(fifo_empty), 64'(1));
    chk("ovf_rd_empty_hold", 64'(fifo_q), 64'(exp_q[15]));

    // Read and write in the same cycle while full: read wins, write dropped.
    fill_pat(1);
    build_exp(2);
    fifo_rd_en = 1'b0;
    pulse_start(1'b0);
    run_to(2 * FW);
    chk("rwfull_full_before", 64'(fifo_full), 64'(1));
    fifo_rd_en = 1'b1;
    cycle();
    fifo_rd_en = 1'b0;
    chk("rwfull_full_after", 64'(fifo_full), 64'(0));
    chk("rwfull_read_cnt", 64'(got.size()), 64'(1));
    if (got.size() > 0) chk("rwfull_read_word", 64'(got[0]), 64'(exp_q[0]));
    wait_done("rwfull", 0);
    chk("rwfull_drop", 64'(drop_cnt), 64'(15));
    chk("rwfull_full_end", 64'(fifo_full), 64'(1));
    fifo_rd_en = 1'b1;
    repeat (17) cycle();
    fifo_rd_en = 1'b0;
    chk("rwfull_nwords", 64'(got.size()), 64'(17));
    for (int i = 1; i < got.size() && i < 17; i++)
      chk($sformatf("rwfull_word%0d", i), 64'(got[i]), 64'(exp_q[(i < 16) ? i : 17]));

    // Read and write in the same cycle while empty: write kept, read ignored.
    fill_pat(1);
    build_exp(2);
    fifo_rd_en = 1'b1;
    pulse_start(1'b0);
    run_to(FW);
    chk("rwempty_empty_before", 64'(fifo_empty), 64'(1));
    cycle();
    chk("rwempty_empty_after", 64'(fifo_empty), 64'(0));
    chk("rwempty_nread", 64'(got.size()), 64'(0));
    cycle();
    chk("rwempty_first", 64'(got.size() > 0 ? got[0] : 36'h0), 64'(exp_q[0]));
    wait_done("rwempty", 0);
    cmp_all("rwempty");

    // Restart mid-capture: flush, clear drops, realign and re-latch mode.
    fill_pat(1);
    fifo_rd_en = 1'b0;
    pulse_start(1'b1);
    run_to(2 * FW + 3);
    chk("rst_run_drop", 64'(drop_cnt), 64'(3));
    fill_pat(1);
    pulse_start(1'b1);
    chk("restart1_empty", 64'(fifo_empty), 64'(1));
    chk("restart1_full", 64'(fifo_full), 64'(0));
    chk("restart1_drop", 64'(drop_cnt), 64'(0));
    chk("restart1_busy", 64'(busy), 64'(1));
    run_to(FW + 3);
    chk("restart2_buffered", 64'(fifo_empty), 64'(0));
    fill_pat(1);
    build_exp(2);
    pulse_start(1'b0);
    chk("restart2_empty", 64'(fifo_empty), 64'(1));
    chk("restart2_drop", 64'(drop_cnt), 64'(0));
    fifo_rd_en = 1'b1;
    wait_done("restart2", 0);
    chk("restart2_done_at", 64'(done_at), 64'(2 * FW + WPFR + 1));
    cmp_all("restart2");

    // Asynchronous reset in the middle of DRAIN.
    fill_pat(1);
    fifo_rd_en = 1'b1;
    pulse_start(1'b0);
    run_to(2 * FW + 4);
    chk("arst_busy_before", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("arst_fifo_q", 64'(fifo_q), 64'(0));
    chk("arst_empty", 64'(fifo_empty), 64'(1));
    chk("arst_full", 64'(fifo_full), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_drop", 64'(drop_cnt), 64'(0));
    @(posedge clk_in);
    #3 rst = 1'b0;
    done_cnt = 0;
    repeat (20) cycle();
    chk("arst_quiet_empty", 64'(fifo_empty), 64'(1));
    chk("arst_quiet_busy", 64'(busy), 64'(0));
    chk("arst_quiet_done", 64'(done_cnt), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
